imm_arbiter: RTL and testbench
==============================

# imm_arbiter

Shared immediate-decode resource for the multicore RISC-V cluster. `NUM_REQ` core front-ends each issue a 32-bit instruction with a valid/ready handshake. The block grants one requester per cycle, decodes the immediate in a shared combinational decoder, and returns a registered result tagged with the requester index. The block sits between the per-core fetch stages and the decode stages and replaces per-core immediate logic.

## Interface
- `NUM_REQ`, default 4: number of requesters. Legal range is 2 to 8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester index.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `req_valid` input, `NUM_REQ` bits: per-requester request valid.
- `req_instr` input, `NUM_REQ`×32 bits: packed instructions, one per requester.
- `req_ready` output, `NUM_REQ` bits: one-hot grant. A request is accepted when `req_valid[i] && req_ready[i]`.
- `resp_valid` output, 1 bit: a result is present.
- `resp_id` output, `ID_W` bits: index of the requester that owns the result.
- `resp_imm` output, 32 bits: the decoded immediate.
- `resp_ready` input, 1 bit: the consumer accepts the result this cycle.

## Operation
- **Requester rules.** A requester holds `req_valid` and `req_instr` stable until it is accepted. `req_ready` is combinational from `req_valid`, the arbiter state and the output-register state.
- **Grant conditions.** At most one bit of `req_ready` is high. Grant is enabled when the output register is empty, or when it is full and `resp_ready=1`, so the result drains and a new one loads in the same cycle.
- **Round-robin pointer.** `rr_ptr` indicates the highest-priority index. The grant goes to the first valid index found scanning `rr_ptr, rr_ptr+1, …`, with wrap modulo `NUM_REQ`. After a grant to index i, `rr_ptr` becomes (i+1) mod `NUM_REQ`. With no grant, `rr_ptr` holds.
- **Immediate decode** (opcode = `instr[6:0]`):
  - 0010011 OP-IMM:
    - funct3 001/101 (shifts): zero-extended `instr[24:20]`.
    - otherwise: sign-extended `instr[31:20]`.
  - 0000011 LOAD and 1100111 JALR: sign-extended `instr[31:20]`.
  - 0100011 STORE: sign-extended `{instr[31:25], instr[11:7]}`.
  - 1100011 BRANCH: sign-extended `{instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}`.
  - 0110111 LUI and 0010111 AUIPC: `{instr[31:12], 12'b0}`.
  - 1101111 JAL: sign-extended `{instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}`.
  - Any other opcode: 0.
- **Output register.** On accept, `resp_valid`, `resp_id` and `resp_imm` load. While `resp_valid=1 && resp_ready=0`, all three hold stable and `req_ready` is all zero.
- **Drain.** `resp_valid` clears on `resp_ready=1` when no new accept occurs in the same cycle.

## Timing
- **Reset values.** `resp_valid`=0, `resp_id`=0, `resp_imm`=0, `rr_ptr`=0. `req_ready` is 0 while `rst_n`=0.
- **Latency.** An accept at edge T produces `resp_valid`=1 after edge T.
- **Throughput.** One result per cycle with `resp_ready` held at 1.
- **Simultaneous requests.** All `NUM_REQ` valid in the same cycle are served in rotation, so each requester is accepted within `NUM_REQ` cycles under continuous `resp_ready`.
- **Pointer wrap.** A grant to index `NUM_REQ`-1 sets `rr_ptr` to 0.
- **Reset mid-operation.** Asserting `rst_n` clears any pending result immediately and asynchronously. The result is lost and no replay occurs.
- **`req_valid` drop.** A `req_valid` drop without an accept is a protocol violation. Behaviour is undefined beyond the arbiter not granting that index.

## Configuration
- Macro: `IMM_ARB_ROUND_ROBIN_EN`.
- Defined: round-robin arbitration as described above.
- Undefined: fixed priority, where the lowest valid index wins. `rr_ptr` is not implemented. Starvation of higher indices under continuous lower-index requests is accepted behaviour.

## Structure
- **Shared package `imm_pkg`:**
  - opcode constants: `OPC_OP_IMM`, `OPC_LOAD`, `OPC_STORE`, `OPC_BRANCH`, `OPC_LUI`, `OPC_AUIPC`, `OPC_JAL`, `OPC_JALR`;
  - funct3 shift constants;
  - `imm_t` typedef (32-bit).
- **Sub-module `imm_decode`:** purely combinational, `instr` in and `imm` out, with the rules above. It is instantiated once, fed by the granted requester's instruction through a one-hot mux.

## Test plan
- **Single request.** `NUM_REQ`=4, only requester 2 valid with 0xFFF00093 → `req_ready`=4'b0100 that cycle; next cycle `resp_valid`=1, `resp_id`=2, `resp_imm`=0xFFFFFFFF.
- **Fairness.** All four valid continuously, `resp_ready`=1:
  - with the macro, `resp_id` sequence 0,1,2,3,0;
  - without it, `resp_id` is always 0.
- **Backpressure.** Result pending, `resp_ready`=0 for 3 cycles → `req_ready`=0, `resp_*` stable. Then `resp_ready`=1 → the pending result drains and the next grant occurs in the same cycle.
- **Decode corners:**

  | Instruction | Expected `resp_imm` |
  |---|---|
  | 0xFE112E23 | 0xFFFFFFFC |
  | 0x12345037 | 0x12345000 |
  | 0x00301093 | 0x00000003 |
  | 0x41F05093 | 0x0000001F |
  | 0x00000033 | 0x00000000 |

- **Reset mid-operation.** Drop `rst_n` while `resp_valid`=1 and `rr_ptr`=3 → all outputs 0 immediately. After release, the first grant with all requesters valid goes to index 0.

Source files
------------

// File: rtl/imm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_pkg : opcode/funct3 constants and immediate type for imm_arbiter
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package imm_pkg;

  typedef logic [31:0] imm_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

endpackage
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_decode : combinational RV32I immediate extraction
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module imm_decode
  import imm_pkg::*;
(
  input  logic [31:0] instr,
  output imm_t        imm
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  always_comb begin
    imm = '0;
    case (opcode)
      OPC_OP_IMM: begin
        // Shift-immediates carry only a 5-bit unsigned shamt.
        if (funct3 == F3_SLLI || funct3 == F3_SRXI)
          imm = {27'b0, instr[24:20]};
        else
          imm = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_LOAD, OPC_JALR:
        imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {instr[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_arbiter : shared immediate decoder with one-grant-per-cycle arbitration
// Rev 1.0 : IMM_ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority
// ---------------------------------------------------------------------------
module imm_arbiter
  import imm_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_instr,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output imm_t                  resp_imm,
  input  logic                  resp_ready
);

  localparam int            SW  = ID_W + 1;
  localparam logic [SW-1:0] N_W = SW'(NUM_REQ);

  logic               grant_en;
  logic               accept;
  logic               found;
  logic [ID_W-1:0]    scan_base;
  logic [ID_W-1:0]    grant_id;
  logic [SW-1:0]      scan_idx;
  logic [NUM_REQ-1:0] grant;
  logic [31:0]        sel_instr;
  imm_t               dec_imm;

`ifdef IMM_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (accept)
      rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  end

  assign scan_base = rr_ptr;
`else
  assign scan_base = '0;
`endif

  // Grant only when the output slot is free or being drained this cycle.
  assign grant_en = rst_n && (!resp_valid || resp_ready);

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, scan_base} + SW'(k);
      if (scan_idx >= N_W)
        scan_idx = scan_idx - N_W;
      if (!found && req_valid[scan_idx[ID_W-1:0]]) begin
        found    = 1'b1;
        grant_id = scan_idx[ID_W-1:0];
      end
    end
    if (grant_en && found)
      grant[grant_id] = 1'b1;
  end

  assign req_ready = grant;
  assign accept    = |grant;

  always_comb begin
    sel_instr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i])
        sel_instr = sel_instr | req_instr[i*32 +: 32];
    end
  end

  imm_decode u_imm_decode (
    .instr (sel_instr),
    .imm   (dec_imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_imm   <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_id    <= grant_id;
      resp_imm   <= dec_imm;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_arbiter.sv
`default_nettype none
// tb_imm_arbiter : directed and randomized checks of imm_arbiter against a behavioural model.
module tb_imm_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
`ifdef IMM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_instr;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  resp_valid;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_imm;
  logic                  resp_ready;

  int errors = 0;
  int checks = 0;

  // Model of the registered result and the priority pointer.
  bit          m_valid;
  int          m_id;
  logic [31:0] m_imm;
  int          m_ptr;

  always #5 clk = ~clk;

  imm_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_instr  (req_instr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_imm   (resp_imm),
    .resp_ready (resp_ready)
  );

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [31:0] ext20, ext25, sgn;
    ext20 = $signed(ins) >>> 20;
    ext25 = $signed(ins) >>> 25;
    sgn   = $signed(ins) >>> 31;
    case (ins[6:0])
      7'h13: return (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ? ((ins >> 20) & 32'h1F) : ext20;
      7'h03, 7'h67: return ext20;
      7'h23: return (ext25 << 5) | ((ins >> 7) & 32'h1F);
      7'h63: return (sgn << 12) | (((ins >> 7) & 32'h1) << 11) |
                    (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
      7'h37, 7'h17: return ins & 32'hFFFFF000;
      7'h6F: return (sgn << 20) | (((ins >> 12) & 32'hFF) << 12) |
                    (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_grant();
    int base;
    if (!rst_n || (m_valid && !resp_ready)) return -1;
    base = RR ? m_ptr : 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (base + k) % NUM_REQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int g);
    logic [NUM_REQ-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [9];
    logic [31:0] r;
    opcs = '{7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h33};
    r = $urandom();
    r[6:0] = opcs[$urandom_range(0, 8)];
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_id    = 0;
    m_imm   = 32'h0;
    m_ptr   = 0;
  endtask

  // Advance one clock edge and update the model with the grant seen before it.
  task automatic tick(output int g);
    g = ref_grant();
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1'b1;
      m_id    = g;
      m_imm   = ref_imm(req_instr[g*32 +: 32]);
      m_ptr   = (g + 1) % NUM_REQ;
    end else if (resp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = '1;
    resp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) req_instr[i*32 +: 32] = rand_instr();
    model_reset();
    #2;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_id !== '0) begin errors++; $display("FAIL reset_resp_id got=%0d exp=0", resp_id); end
    checks++; if (resp_imm !== 32'h0) begin errors++; $display("FAIL reset_resp_imm got=%h exp=0", resp_imm); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_held_valid got=%b exp=0", resp_valid); end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int g;
    req_valid = 4'b0100;
    req_instr[2*32 +: 32] = 32'hFFF00093;
    resp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
    tick(g);
    req_valid = '0;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", resp_valid); end
    checks++; if (resp_id !== 2'd2) begin errors++; $display("FAIL single_id got=%0d exp=2", resp_id); end
    checks++; if (resp_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL single_imm got=%h exp=ffffffff", resp_imm); end
    tick(g);
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", resp_valid); end
    tick(g);
  endtask

  task automatic test_fairness();
    int g;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) req_instr[i*32 +: 32] = (32'(i + 1) << 20) | 32'h93;
    req_valid  = '1;
    resp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      int exp_g, exp_prev;
      exp_g    = RR ? (c % NUM_REQ) : 0;
      exp_prev = RR ? ((c + NUM_REQ - 1) % NUM_REQ) : 0;
      @(negedge clk);
      if (c < 5) begin
        checks++;
        if (req_ready !== onehot(exp_g)) begin
          errors++; $display("FAIL fair_grant c=%0d got=%b exp=%b", c, req_ready, onehot(exp_g));
        end
      end
      if (c >= 1) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== exp_prev[ID_W-1:0] || resp_imm !== 32'(exp_prev + 1)) begin
          errors++; $display("FAIL fair_resp c=%0d got v=%b id=%0d imm=%h exp id=%0d imm=%0d",
                             c, resp_valid, resp_id, resp_imm, exp_prev, exp_prev + 1);
        end
      end
      tick(g);
    end
  endtask

  task automatic test_backpressure();
    int g, g_exp, save_id;
    logic [31:0] save_imm;
    resp_ready = 1'b0;
    save_id  = m_id;
    save_imm = m_imm;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_ready c=%0d got=%b exp=0", c, req_ready); end
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== save_id[ID_W-1:0] || resp_imm !== save_imm) begin
        errors++; $display("FAIL bp_hold c=%0d got v=%b id=%0d imm=%h exp v=1 id=%0d imm=%h",
                           c, resp_valid, resp_id, resp_imm, save_id, save_imm);
      end
      tick(g);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    g_exp = ref_grant();
    checks++; if (req_ready !== onehot(g_exp) || req_ready === '0) begin
      errors++; $display("FAIL bp_release_grant got=%b exp=%b", req_ready, onehot(g_exp));
    end
    tick(g);
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_id !== g_exp[ID_W-1:0]) begin
      errors++; $display("FAIL bp_next_resp got v=%b id=%0d exp v=1 id=%0d", resp_valid, resp_id, g_exp);
    end
    req_valid = '0;
    tick(g);
  endtask

  task automatic test_decode();
    int g;
    logic [31:0] ins [7];
    logic [31:0] exp [7];
    ins = '{32'hFE112E23, 32'h12345037, 32'h00301093, 32'h41F05093, 32'h00000033, 32'hFE000EE3, 32'h0080006F};
    exp = '{32'hFFFFFFFC, 32'h12345000, 32'h00000003, 32'h0000001F, 32'h00000000, 32'hFFFFFFFC, 32'h00000008};
    resp_ready = 1'b1;
    for (int t = 0; t < 7; t++) begin
      req_valid = 4'b0010;
      req_instr[1*32 +: 32] = ins[t];
      @(negedge clk);
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL dec_grant t=%0d got=%b exp=0010", t, req_ready); end
      tick(g);
      req_valid = '0;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_imm !== exp[t]) begin
        errors++; $display("FAIL dec_imm instr=%h got v=%b id=%0d imm=%h exp imm=%h", ins[t], resp_valid, resp_id, resp_imm, exp[t]);
      end
      tick(g);
    end
  endtask

  task automatic test_random();
    int g, g2;
    req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_instr[i*32 +: 32] = rand_instr();
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      g = ref_grant();
      checks++; if (req_ready !== onehot(g)) begin errors++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, req_ready, onehot(g)); end
      checks++; if (resp_valid !== m_valid) begin errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, resp_valid, m_valid); end
      if (m_valid) begin
        checks++; if (resp_id !== m_id[ID_W-1:0] || resp_imm !== m_imm) begin
          errors++; $display("FAIL rnd_resp c=%0d got id=%0d imm=%h exp id=%0d imm=%h", c, resp_id, resp_imm, m_id, m_imm);
        end
      end
      tick(g2);
      if (g2 >= 0) req_valid[g2] = 1'b0;
    end
    req_valid = '0;
    resp_ready = 1'b1;
    tick(g2);
  endtask

  task automatic test_reset_mid();
    int g;
    do_reset();
    resp_ready = 1'b0;
    req_valid  = 4'b0100;
    req_instr[2*32 +: 32] = 32'hFFF00093;
    @(negedge clk);
    tick(g);
    req_valid = '1;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2) begin
      errors++; $display("FAIL mid_pending got v=%b id=%0d exp v=1 id=2", resp_valid, resp_id);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (resp_valid !== 1'b0 || resp_id !== '0 || resp_imm !== 32'h0 || req_ready !== '0) begin
      errors++; $display("FAIL mid_async_clear got v=%b id=%0d imm=%h rdy=%b exp all 0", resp_valid, resp_id, resp_imm, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
    tick(g);
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0) begin
      errors++; $display("FAIL mid_first_resp got v=%b id=%0d exp v=1 id=0", resp_valid, resp_id);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_decode();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
